unsigned_sqrt_unit: RTL
=======================

# unsigned_sqrt_unit

- Iterative radix-2 (two radicand bits per cycle) unsigned integer square-root engine.
- Implements the sqrt end of the unsigned sqrt request/response interface: a requester supplies radicand and start; this block returns result, remainder and done.
- Sits beside the divider inside the FP/ALU datapath, shared by any requester that needs an integer square root.

## Interface
- DATA_WIDTH, 32, radicand/result/remainder width; must be even and ≥ 4
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request strobe; accepted only when not busy
- radicand  in  DATA_WIDTH  operand, sampled in the accepting cycle
- result  out  DATA_WIDTH  floor(sqrt(radicand)), zero-extended from DATA_WIDTH/2 bits
- remainder  out  DATA_WIDTH  radicand − result², zero-extended from DATA_WIDTH/2+1 bits
- done  out  1  one-cycle pulse: result/remainder valid

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- IDLE:
  - start=1 loads rad_shift ← radicand, rem ← 0, root ← 0, counter ← DATA_WIDTH/2−1.
  - Go to BUSY.
- BUSY, one iteration per cycle:
  - rem_t = {rem, rad_shift[MSB:MSB−1]}; trial = {root, 2'b01}.
  - If rem_t ≥ trial: rem ← rem_t − trial, root ← {root, 1}. Else: rem ← rem_t, root ← {root, 0}.
  - rad_shift ← rad_shift << 2.
- Widths: rem register is DATA_WIDTH/2+2 bits (rem_t never exceeds that); root is DATA_WIDTH/2 bits; comparison and subtraction are unsigned at rem width.
- Counter decrements each iteration. On the iteration with counter==0: go to IDLE and register done=1 for the next cycle.
- result/remainder outputs are the root/rem registers zero-extended. They hold their value until the next accepted start, which reloads them immediately.
- start while BUSY is ignored; radicand changes while BUSY have no effect.
- start in the same cycle as done (state IDLE) is accepted; back-to-back operation carries no bubble.
- rst, including mid-operation: state IDLE, done=0, root=0, rem=0, rad_shift=0, counter=0. Any in-flight operation is discarded and no done is produced for it.

## Timing
- Start accepted at the end of cycle 0.
- BUSY for cycles 1..DATA_WIDTH/2; one iteration completes at the end of each.
- done=1 in cycle DATA_WIDTH/2+1 (cycle 17 for default), for exactly one cycle.
- Throughput: one result per DATA_WIDTH/2+1 cycles, with start issued in each done cycle.
- Reset values: done=0, result=0, remainder=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package (cva5_types):
  - sqrt_state_t enum {SQRT_IDLE, SQRT_BUSY}.
  - Width constant SQRT_ROOT_W = DATA_WIDTH/2; counter width $clog2(SQRT_ROOT_W).
- One natural sub-module: unsigned_sqrt_step, purely combinational. Takes rem, root and the 2 radicand bits; produces next rem and next root. Enables future unrolling to 2 iterations/cycle.
- Top holds the state register, counter, shift registers and done flop.

## Test plan
- radicand=16, start pulse → done in cycle 17, result=4, remainder=0. done is low in cycles 1–16 and 18.
- radicand=17 → result=4, remainder=1. radicand=0 → result=0, remainder=0.
- radicand=0xFFFFFFFF → result=0x0000FFFF, remainder=0x0001FFFE. radicand=0x40000000 → result=0x8000, remainder=0.
- Back-to-back:
  - radicand=100, then start=1 with radicand=99 in the done cycle → first result 10/0.
  - Second done exactly 17 cycles later with 9/18.
- start=1 with radicand=25 held during BUSY of a radicand=81 operation → single done with 9/0; the extra starts are ignored.
- rst asserted in cycle 8 of an operation → next cycle done=0, result=0, remainder=0, state IDLE. A new start then completes normally in 17 cycles.
- Random sweep of 10k radicands against a floor-sqrt reference model; also check remainder ≤ 2·result.

Source files
------------

// File: rtl/unsigned_sqrt_unit_pkg.sv
// Shared types and width helpers for the iterative unsigned square-root engine.
package cva5_types;

  typedef enum logic [0:0] {
    SQRT_IDLE = 1'b0,
    SQRT_BUSY = 1'b1
  } sqrt_state_t;

  function automatic int sqrt_root_w(input int data_width);
    return data_width / 2;
  endfunction

  // Counter must hold SQRT_ROOT_W-1; keep at least one bit for the narrowest build.
  function automatic int sqrt_cnt_w(input int data_width);
    return ($clog2(data_width / 2) < 1) ? 1 : $clog2(data_width / 2);
  endfunction

endpackage

// File: rtl/unsigned_sqrt_unit_step.sv
// One restoring radix-2 square-root iteration: consumes two radicand bits, yields one root bit.
module unsigned_sqrt_unit_step #(
  parameter int ROOT_W = 16
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        rad_bits,
  output logic [ROOT_W+1:0] rem_next,
  output logic [ROOT_W-1:0] root_next
);

  logic [ROOT_W+1:0] rem_t;
  logic [ROOT_W+1:0] trial;
  logic              ge;

  // Compare at full width so the top remainder bits still take part, then
  // subtract at remainder width where the result is known to fit.
  always_comb begin
    rem_t = {rem[ROOT_W-1:0], rad_bits};
    trial = {root, 2'b01};
    ge    = ({rem, rad_bits} >= {2'b00, root, 2'b01});
    if (ge) begin
      rem_next = rem_t - trial;
    end else begin
      rem_next = rem_t;
    end
    root_next = {root[ROOT_W-2:0], ge};
  end

endmodule

// File: rtl/unsigned_sqrt_unit.sv
// Iterative unsigned integer square root: one root bit per cycle, done pulses after DATA_WIDTH/2 iterations.
module unsigned_sqrt_unit
  import cva5_types::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] radicand,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);

  localparam int SQRT_ROOT_W = sqrt_root_w(DATA_WIDTH);
  localparam int CNT_W       = sqrt_cnt_w(DATA_WIDTH);
  localparam int REM_W       = SQRT_ROOT_W + 2;

  sqrt_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [SQRT_ROOT_W-1:0]  root_q, root_d;
  logic                    done_q, done_d;

  logic [REM_W-1:0]        step_rem;
  logic [SQRT_ROOT_W-1:0]  step_root;

  unsigned_sqrt_unit_step #(
    .ROOT_W (SQRT_ROOT_W)
  ) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .rad_bits  (rad_q[DATA_WIDTH-1:DATA_WIDTH-2]),
    .rem_next  (step_rem),
    .root_next (step_root)
  );

  // Next-state logic; a start in the done cycle is accepted because state is already IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    done_d  = 1'b0;
    case (state_q)
      SQRT_IDLE: begin
        if (start) begin
          rad_d   = radicand;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_W'(SQRT_ROOT_W - 1);
          state_d = SQRT_BUSY;
        end else begin
          state_d = SQRT_IDLE;
        end
      end
      SQRT_BUSY: begin
        rem_d  = step_rem;
        root_d = step_root;
        rad_d  = {rad_q[DATA_WIDTH-3:0], 2'b00};
        if (cnt_q == '0) begin
          state_d = SQRT_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = SQRT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SQRT_IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      done_q  <= done_d;
    end
  end

  assign result    = DATA_WIDTH'(root_q);
  assign remainder = DATA_WIDTH'(rem_q);
  assign done      = done_q;

endmodule
